udp_cmd_tx: RTL and testbench

Command-packet transmit stage feeding the UDP/MAC stack (`udp_mac_complete`). On a start pulse it:

- reads a block of 16-bit command words from the controller's output RAM, starting at address 0;
- presents one UDP header to the stack;
- streams the words as a big-endian byte AXI-stream payload.

It replaces the ad-hoc word-to-byte path between the output RAM and `ctrl_out_udp_payload_axis_*`.

---
 rtl/ultrasound_pkg.sv | 21 ++
 rtl/udp_cmd_tx.sv | 205 ++++++++++++++++++++
 tb/tb_udp_cmd_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ultrasound_pkg.sv
// Shared types and constants for the ultrasound controller's UDP command path.
// UDP_CMD_TX_SEQ_EN adds the sequence-number states to the transmit FSM.
package ultrasound_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam logic [15:0] CTRL_UDP_PORT = 16'h1235;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    FIN  = 3'd4
`ifdef UDP_CMD_TX_SEQ_EN
    ,
    SEQH = 3'd5,
    SEQL = 3'd6
`endif
  } tx_state_e;

endpackage

// File: rtl/udp_cmd_tx.sv
// Reads tx_len RAM words from address 0 and sends them as one UDP packet (big-endian bytes),
// 1 cycle start->header, 1 byte/cycle under tready; UDP_CMD_TX_SEQ_EN prepends a 16-bit sequence number.
module udp_cmd_tx
  import ultrasound_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] DEST_PORT  = 16'h0000,
  parameter logic [15:0] SRC_PORT   = 16'h3456
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   tx_len,
  input  logic [31:0]           dest_ip,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [15:0]           ram_q,
  output logic                  tx_udp_hdr_valid,
  input  logic                  tx_udp_hdr_ready,
  output logic [31:0]           tx_ip_dest_ip,
  output logic [15:0]           tx_udp_source_port,
  output logic [15:0]           tx_udp_dest_port,
  output logic [15:0]           tx_udp_length,
  output logic [7:0]            tx_udp_payload_axis_tdata,
  output logic                  tx_udp_payload_axis_tvalid,
  input  logic                  tx_udp_payload_axis_tready,
  output logic                  tx_udp_payload_axis_tlast,
  output logic                  tx_udp_payload_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]         LEN_ONE = LW'(1);
  localparam logic [LW-1:0]         MAX_LEN = LW'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

  tx_state_e             state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [31:0]           ip_q, ip_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [15:0]           word_q, word_d;
  logic [7:0]            lo_q, lo_d;
  logic                  last_q, last_d;
  logic                  ld_q, ld_d;
  logic                  err_q, err_d;
`ifdef UDP_CMD_TX_SEQ_EN
  logic [15:0]           seq_q, seq_d;
`endif

  logic                  len_ok;
  logic                  is_last;
  logic [ADDR_WIDTH-1:0] idx_inc;
  logic [15:0]           udp_len;
  logic                  hdr_vld;

  assign len_ok  = (tx_len != '0) && (tx_len <= MAX_LEN);
  assign is_last = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign idx_inc = idx_q + IDX_ONE;
`ifdef UDP_CMD_TX_SEQ_EN
  assign udp_len = 16'(UDP_HDR_BYTES) + 16'd2 + 16'({len_q, 1'b0});
`else
  assign udp_len = 16'(UDP_HDR_BYTES) + 16'({len_q, 1'b0});
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ip_d    = ip_q;
    idx_d   = idx_q;
    word_d  = word_q;
    lo_d    = lo_q;
    last_d  = last_q;
    ld_d    = 1'b0;
    err_d   = 1'b0;
`ifdef UDP_CMD_TX_SEQ_EN
    seq_d   = seq_q;
`endif
    ram_rd  = 1'b0;
    ram_addr = '0;
    hdr_vld = 1'b0;
    tx_udp_payload_axis_tvalid = 1'b0;
    tx_udp_payload_axis_tdata  = 8'h00;
    tx_udp_payload_axis_tlast  = 1'b0;
    done    = err_q;

    // RAM data arrives one cycle after each read strobe
    if (ld_q) begin
      word_d = ram_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = tx_len;
            ip_d    = dest_ip;
            idx_d   = '0;
            ram_rd  = 1'b1;
            ld_d    = 1'b1;
            state_d = HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HDR: begin
        hdr_vld = 1'b1;
        if (tx_udp_hdr_ready) begin
`ifdef UDP_CMD_TX_SEQ_EN
          state_d = SEQH;
`else
          state_d = HI;
`endif
        end
      end
`ifdef UDP_CMD_TX_SEQ_EN
      SEQH: begin
        tx_udp_payload_axis_tvalid = 1'b1;
        tx_udp_payload_axis_tdata  = seq_q[15:8];
        if (tx_udp_payload_axis_tready) state_d = SEQL;
      end
      SEQL: begin
        tx_udp_payload_axis_tvalid = 1'b1;
        tx_udp_payload_axis_tdata  = seq_q[7:0];
        if (tx_udp_payload_axis_tready) state_d = HI;
      end
`endif
      HI: begin
        tx_udp_payload_axis_tvalid = 1'b1;
        tx_udp_payload_axis_tdata  = word_q[15:8];
        if (tx_udp_payload_axis_tready) begin
          lo_d   = word_q[7:0];
          last_d = is_last;
          // Prefetch the next word while the low byte goes out
          if (!is_last) begin
            ram_rd   = 1'b1;
            ram_addr = idx_inc;
            idx_d    = idx_inc;
            ld_d     = 1'b1;
          end
          state_d = LO;
        end
      end
      LO: begin
        tx_udp_payload_axis_tvalid = 1'b1;
        tx_udp_payload_axis_tdata  = lo_q;
        tx_udp_payload_axis_tlast  = last_q;
        if (tx_udp_payload_axis_tready) begin
          state_d = last_q ? FIN : HI;
        end
      end
      FIN: begin
        done    = 1'b1;
`ifdef UDP_CMD_TX_SEQ_EN
        seq_d   = seq_q + 16'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      ip_q    <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      lo_q    <= '0;
      last_q  <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef UDP_CMD_TX_SEQ_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ip_q    <= ip_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      lo_q    <= lo_d;
      last_q  <= last_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
`ifdef UDP_CMD_TX_SEQ_EN
      seq_q   <= seq_d;
`endif
    end
  end

  // Header fields read as zero outside the header handshake
  assign tx_udp_hdr_valid   = hdr_vld;
  assign tx_ip_dest_ip      = hdr_vld ? ip_q : 32'h0;
  assign tx_udp_source_port = hdr_vld ? SRC_PORT : 16'h0;
  assign tx_udp_dest_port   = hdr_vld ? DEST_PORT : 16'h0;
  assign tx_udp_length      = hdr_vld ? udp_len : 16'h0;
  assign tx_udp_payload_axis_tuser = 1'b0;
  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_udp_cmd_tx.sv
// Randomized bench for udp_cmd_tx against a byte-queue packet model; build with
// UDP_CMD_TX_SEQ_EN defined to expect the sequence-number prefix.
module tb_udp_cmd_tx;

  localparam int AW = 10;
  localparam logic [15:0] DPORT = 16'hBEEF;
  localparam logic [15:0] SPORT = 16'h3456;
  localparam int CYC_MAX = 5000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   tx_len = '0;
  logic [31:0]   dest_ip = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [15:0]   ram_q = '0;
  logic          hdr_valid;
  logic          hdr_ready = 1'b0;
  logic [31:0]   ip_o;
  logic [15:0]   sport_o, dport_o, len_o;
  logic [7:0]    tdata;
  logic          tvalid, tlast, tuser;
  logic          tready = 1'b0;
  logic          busy, done, err;

  udp_cmd_tx #(.ADDR_WIDTH(AW), .DEST_PORT(DPORT), .SRC_PORT(SPORT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_len(tx_len), .dest_ip(dest_ip),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
    .tx_udp_hdr_valid(hdr_valid), .tx_udp_hdr_ready(hdr_ready),
    .tx_ip_dest_ip(ip_o), .tx_udp_source_port(sport_o), .tx_udp_dest_port(dport_o),
    .tx_udp_length(len_o),
    .tx_udp_payload_axis_tdata(tdata), .tx_udp_payload_axis_tvalid(tvalid),
    .tx_udp_payload_axis_tready(tready), .tx_udp_payload_axis_tlast(tlast),
    .tx_udp_payload_axis_tuser(tuser),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] seq_e = 16'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic any_out();
    return |{ram_addr, ram_rd, hdr_valid, ip_o, sport_o, dport_o, len_o,
             tdata, tvalid, tlast, tuser, busy, done, err};
  endfunction

  task automatic send(input int len, input int mode, input int hdr_dly, input int abort_at);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [31:0] ip_e;
    logic [79:0] snap, cur;
    logic [7:0] prev_dat;
    bit ok, hsnap, prev_tv, prev_rdy, prev_last, tog;
    int cyc, hdr_wait, nreads, maxaddr, hdr_acc, first_tv, first_hs, last_hs, done_cyc;
    int stall_bad, hstab_bad, tlast_bad, bytes_bad, err_seen, busy_bad, hlen;

    ok = (len >= 1) && (len <= (1 << AW));
    hsnap = 0; prev_tv = 0; prev_rdy = 0; prev_last = 0; prev_dat = '0; tog = 1;
    cyc = 0; hdr_wait = 0; nreads = 0; maxaddr = 0; hdr_acc = -1; first_tv = -1;
    first_hs = -1; last_hs = -1; done_cyc = -1; snap = '0;
    stall_bad = 0; hstab_bad = 0; tlast_bad = 0; bytes_bad = 0; err_seen = 0; busy_bad = 0;

    hlen = 8 + 2 * len;
`ifdef UDP_CMD_TX_SEQ_EN
    hlen = hlen + 2;
    exp_q.push_back(seq_e[15:8]);
    exp_q.push_back(seq_e[7:0]);
`endif
    for (int w = 0; w < len && w < (1 << AW); w++) begin
      exp_q.push_back(mem[w][15:8]);
      exp_q.push_back(mem[w][7:0]);
    end

    ip_e = $urandom;
    @(negedge clk);
    start = 1'b1; tx_len = (AW+1)'(len); dest_ip = ip_e;
    #1;
    if (ok) begin
      chk("rd_first", 32'({ram_rd, ram_addr}), 32'({1'b1, {AW{1'b0}}}));
      nreads = 1;
    end
    @(negedge clk);
    start = 1'b0;
    if (!ok) begin
      chk("err_resp", 32'({err, done, hdr_valid, busy}), 32'(4'b1100));
      @(negedge clk);
      chk("err_pulse", 32'({err, done, hdr_valid}), 32'h0);
      return;
    end
    chk("hdr_lat", 32'(hdr_valid), 32'h1);

    while (cyc < CYC_MAX) begin
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        rst_n = 1'b0; start = 1'b0; hdr_ready = 1'b0; tready = 1'b1;
        @(negedge clk);
        chk("rst_outs", 32'(any_out()), 32'h0);
        rst_n = 1'b1;
        seq_e = 16'h0;
        return;
      end
      if (!busy) busy_bad++;
      if (err) err_seen++;
      if (prev_tv && !prev_rdy && (!tvalid || tdata != prev_dat || tlast != prev_last))
        stall_bad++;
      if (hdr_valid) begin
        cur = {ip_o, sport_o, dport_o, len_o};
        if (!hsnap) begin
          chk("hdr_len", 32'(len_o), 32'(hlen));
          chk("hdr_ports", {sport_o, dport_o}, {SPORT, DPORT});
          chk("hdr_ip", ip_o, ip_e);
          snap = cur; hsnap = 1;
        end else if (cur != snap) hstab_bad++;
        hdr_ready = (hdr_wait >= hdr_dly);
        if (hdr_ready) hdr_acc = cyc;
        hdr_wait++;
      end else hdr_ready = 1'b0;
      tready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom % 2);
      tog = ~tog;
      // a start while busy must be ignored, even with an illegal length
      start = ($urandom % 8 == 0); tx_len = '0;
      #1;
      if (ram_rd) begin
        nreads++;
        if (int'(ram_addr) > maxaddr) maxaddr = int'(ram_addr);
      end
      if (tvalid && first_tv < 0) first_tv = cyc;
      if (tvalid && tready) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (tlast != (got_q.size() + 1 == exp_q.size())) tlast_bad++;
        got_q.push_back(tdata);
      end
      prev_tv = tvalid; prev_rdy = tready; prev_dat = tdata; prev_last = tlast;
      if (done) begin done_cyc = cyc; break; end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (cyc >= CYC_MAX) chk("timeout", 32'h1, 32'h0);

    chk("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) bytes_bad++;
    chk("bytes_bad", 32'(bytes_bad), 32'h0);
    chk("tlast_bad", 32'(tlast_bad), 32'h0);
    chk("nreads", 32'(nreads), 32'(len));
    chk("max_addr", 32'(maxaddr), 32'(len - 1));
    chk("first_byte_lat", 32'(first_tv), 32'(hdr_acc + 1));
    chk("done_lat", 32'(done_cyc), 32'(last_hs + 1));
    chk("stall_bad", 32'(stall_bad), 32'h0);
    chk("hdr_stable_bad", 32'(hstab_bad), 32'h0);
    chk("busy_bad", 32'(busy_bad), 32'h0);
    chk("err_in_pkt", 32'(err_seen), 32'h0);
    if (mode == 0) chk("throughput", 32'(last_hs - first_hs + 1), 32'(exp_q.size()));
    @(negedge clk);
    chk("done_pulse", 32'({done, busy, tvalid}), 32'h0);
    seq_e = seq_e + 16'h1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0F0E;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(any_out()), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 32'(any_out()), 32'h0);

    send(3, 0, 0, -1);
    send(3, 1, 5, -1);
    send(0, 0, 0, -1);
    send(1025, 0, 0, -1);
    send(1024, 0, 0, -1);
    send(10, 0, 0, 4);
    send(3, 0, 0, -1);
    for (int k = 0; k < 6; k++) send($urandom_range(1, 40), 2, $urandom_range(0, 3), -1);
    send(1, 1, 2, -1);
    send(2, 2, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
